// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the dual-lane ALU sequencer/checker.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Vector layout {sel2,sel1,B1,A1,B0,A0}; the full concatenation is 20 bits
  localparam int VEC_W   = 20;
  localparam int OFS_A0  = 0;
  localparam int OFS_B0  = 4;
  localparam int OFS_A1  = 8;
  localparam int OFS_B1  = 12;
  localparam int OFS_SL1 = 16;
  localparam int OFS_SL2 = 18;

  typedef struct packed {
    logic [1:0] sel2;
    logic [1:0] sel1;
    logic [3:0] b1;
    logic [3:0] a1;
    logic [3:0] b0;
    logic [3:0] a0;
  } alu_vec_t;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/alu_seq_lfsr.sv
// 16-bit vector-source LFSR: synchronous load of a seed, single-step advance.
module alu_seq_lfsr
  import alu_seq_pkg::*;
#(
  parameter logic [15:0] RST_VAL = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // Load wins over advance so a start never consumes the seed value
  always_ff @(posedge clk) begin
    if (rst)       state <= RST_VAL;
    else if (load) state <= seed;
    else if (adv)  state <= lfsr_step(state);
  end

endmodule

// File: rtl/alu_lockstep_seq.sv
// Vector sequencer and lane-compare checker for the dual 4-bit ALU block.
// Issues one LFSR-derived vector per cycle, tracks it through a pipe matched
// to the ALU latency and scores the returned x/y compare bits.
module alu_lockstep_seq
  import alu_seq_pkg::*;
#(
  parameter int          ALU_LAT  = 1,
  parameter int          CNT_W    = 16,
  parameter logic [15:0] SEED_DEF = LFSR_SEED_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  input  logic [15:0]      seed_i,
  input  logic             lockstep_i,
  input  logic             inj_en_i,
  input  logic [CNT_W-1:0] inj_idx_i,
  output logic [3:0]       A0_o,
  output logic [3:0]       B0_o,
  output logic [3:0]       A1_o,
  output logic [3:0]       B1_o,
  output logic [1:0]       sel1_o,
  output logic [1:0]       sel2_o,
  input  logic [3:0]       x_i,
  input  logic             y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fail_vld_o,
  output logic [CNT_W-1:0] fail_idx_o,
  output logic [VEC_W-1:0] fail_vec_o
);

  localparam int              DW    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [DW-1:0]   D_END = DW'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] idx_q, nv_q;
  logic [DW-1:0]    drain_cnt;
  logic [15:0]      lfsr_q;
  logic [15:0]      seed_eff;
  alu_vec_t         vec_cur, op_q;

  logic                        accept, issue, last_issue, drain_end;
  logic [ALU_LAT:0]            vld_pipe;
  logic [ALU_LAT:0][CNT_W-1:0] idx_pipe;
  alu_vec_t [ALU_LAT:0]        vec_pipe;
  logic                        mis;

  assign accept     = (state == IDLE) && start_i;
  assign issue      = (state == ISSUE);
  assign last_issue = issue && (idx_q == nv_q - ONE);
  assign drain_end  = (state == DRAIN) && (drain_cnt == D_END);
  assign seed_eff   = (seed_i == 16'h0000) ? SEED_DEF : seed_i;

  alu_seq_lfsr #(.RST_VAL(SEED_DEF)) u_lfsr (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .load  (accept),
    .adv   (issue),
    .seed  (seed_eff),
    .state (lfsr_q)
  );

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state: empty runs go straight to DONE; DRAIN covers the ALU latency
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = (num_vec_i == '0) ? DONE : ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector index, latched run length and drain timer
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      idx_q     <= '0;
      nv_q      <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        idx_q <= '0;
        nv_q  <= num_vec_i;
      end else if (issue) begin
        idx_q <= idx_q + ONE;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  // Busy spans accept..DONE; done is a registered pulse following DONE
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      if (accept)              busy_o <= 1'b1;
      else if (state == DONE)  busy_o <= 1'b0;
      done_o <= (state == DONE);
    end
  end

  // Map the current LFSR word onto both lanes, with optional A1[0] fault
  always_comb begin
    vec_cur      = '0;
    vec_cur.a0   = lfsr_q[3:0];
    vec_cur.b0   = lfsr_q[7:4];
    vec_cur.sel1 = lfsr_q[9:8];
    if (lockstep_i) begin
      vec_cur.a1   = lfsr_q[3:0];
      vec_cur.b1   = lfsr_q[7:4];
      vec_cur.sel2 = lfsr_q[9:8];
    end else begin
      vec_cur.a1   = lfsr_q[13:10];
      vec_cur.b1   = {lfsr_q[1:0], lfsr_q[15:14]};
      vec_cur.sel2 = lfsr_q[11:10];
    end
    if (inj_en_i && (idx_q == inj_idx_i)) vec_cur.a1[0] = ~vec_cur.a1[0];
  end

  // Operand registers: update only on issue, hold otherwise
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)   op_q <= '0;
    else if (issue) op_q <= vec_cur;
  end

  assign A0_o   = op_q.a0;
  assign B0_o   = op_q.b0;
  assign A1_o   = op_q.a1;
  assign B1_o   = op_q.b1;
  assign sel1_o = op_q.sel1;
  assign sel2_o = op_q.sel2;

  // Stage 0 lines up with the operand registers; stage ALU_LAT with x_i/y_i
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[ALU_LAT-1:0], issue};
  end

  // Payload of the pipe needs no reset; only the valid bits qualify it
  always_ff @(posedge wb_clk_i) begin
    idx_pipe[0] <= idx_q;
    vec_pipe[0] <= vec_cur;
    for (int i = 1; i <= ALU_LAT; i++) begin
      idx_pipe[i] <= idx_pipe[i-1];
      vec_pipe[i] <= vec_pipe[i-1];
    end
  end

  assign mis = vld_pipe[ALU_LAT] && ((|x_i) || y_i);

  // Score results: saturating error count and first-failure capture
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_cnt_o  <= '0;
      fail_vld_o <= 1'b0;
      fail_idx_o <= '0;
      fail_vec_o <= '0;
    end else if (accept) begin
      err_cnt_o  <= '0;
      fail_vld_o <= 1'b0;
      fail_idx_o <= '0;
      fail_vec_o <= '0;
    end else if (mis) begin
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ONE;
      if (!fail_vld_o) begin
        fail_vld_o <= 1'b1;
        fail_idx_o <= idx_pipe[ALU_LAT];
        fail_vec_o <= vec_pipe[ALU_LAT];
      end
    end
  end

endmodule

// File: tb/tb_alu_lockstep_seq.sv
// Directed bench for alu_lockstep_seq with a behavioural dual-lane ALU.
module tb_alu_lockstep_seq;

  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [CNT_W-1:0] num_vec_i;
  logic [15:0]      seed_i;
  logic             lockstep_i;
  logic             inj_en_i;
  logic [CNT_W-1:0] inj_idx_i;
  logic [3:0]       A0_o, B0_o, A1_o, B1_o;
  logic [1:0]       sel1_o, sel2_o;
  logic [3:0]       x_i;
  logic             y_i;
  logic             busy_o, done_o, fail_vld_o;
  logic [CNT_W-1:0] err_cnt_o, fail_idx_o;
  logic [19:0]      fail_vec_o;
  logic             force_y = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_lockstep_seq #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .num_vec_i(num_vec_i),
    .seed_i(seed_i), .lockstep_i(lockstep_i), .inj_en_i(inj_en_i), .inj_idx_i(inj_idx_i),
    .A0_o(A0_o), .B0_o(B0_o), .A1_o(A1_o), .B1_o(B1_o), .sel1_o(sel1_o), .sel2_o(sel2_o),
    .x_i(x_i), .y_i(y_i), .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .fail_vld_o(fail_vld_o), .fail_idx_o(fail_idx_o), .fail_vec_o(fail_vec_o)
  );

  // Behavioural lane ALU: add, sub, xor, pass-A (every op is sensitive to A)
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  logic [3:0] xs [ALU_LAT];
  logic       ys [ALU_LAT];
  logic [4:0] r1, r2;
  assign r1 = alu(A0_o, B0_o, sel1_o);
  assign r2 = alu(A1_o, B1_o, sel2_o);

  always @(posedge clk) begin
    xs[0] <= r1[3:0] ^ r2[3:0];
    ys[0] <= r1[4] ^ r2[4];
    for (int i = 1; i < ALU_LAT; i++) begin
      xs[i] <= xs[i-1];
      ys[i] <= ys[i-1];
    end
  end
  assign x_i = xs[ALU_LAT-1];
  assign y_i = ys[ALU_LAT-1] | force_y;

  // Reference vector generator
  function automatic logic [15:0] lf_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [19:0] vec_at(input logic [15:0] seed, input int k, input bit ls,
                                         input bit inj, input logic [15:0] inj_idx);
    logic [15:0] l;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] s1, s2;
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    for (int i = 0; i < k; i++) l = lf_next(l);
    a0 = l[3:0]; b0 = l[7:4]; s1 = l[9:8];
    if (ls) begin a1 = a0; b1 = b0; s2 = s1; end
    else begin a1 = l[13:10]; b1 = {l[1:0], l[15:14]}; s2 = l[11:10]; end
    if (inj && k == int'(inj_idx)) a1[0] = ~a1[0];
    return {s2, s1, b1, a1, b0, a0};
  endfunction

  typedef struct {
    logic [15:0] seed;
    logic [15:0] nv;
    bit          ls;
    bit          inj;
    logic [15:0] inj_idx;
    int          rp;        // cycle at which start is re-pulsed, -1 = never
    bit          use_model;
    logic [15:0] exp_err;
    bit          exp_fvld;
    logic [15:0] exp_fidx;
  } vec_t;

  function automatic void model_exp(input vec_t t, output int err, output int first);
    logic [19:0] v;
    logic [4:0]  o1, o2;
    err = 0; first = -1;
    for (int k = 0; k < int'(t.nv); k++) begin
      v  = vec_at(t.seed, k, t.ls, t.inj, t.inj_idx);
      o1 = alu(v[3:0], v[7:4], v[17:16]);
      o2 = alu(v[11:8], v[15:12], v[19:18]);
      if (o1 != o2) begin
        if (err < 65535) err++;
        if (first < 0) first = k;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_run(input vec_t t);
    logic [19:0] ev, av, ops0;
    int cyc, exp_done, e_err, e_first;
    bit got;
    ops0 = {sel2_o, sel1_o, B1_o, A1_o, B0_o, A0_o};
    seed_i = t.seed; num_vec_i = t.nv; lockstep_i = t.ls;
    inj_en_i = t.inj; inj_idx_i = t.inj_idx; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_on_accept", busy_o, 1);
    cyc = 0; got = 0;
    while (!got && cyc < int'(t.nv) + ALU_LAT + 20) begin
      if (cyc == t.rp) begin start_i = 1'b1; num_vec_i = 16'd2; seed_i = 16'hFFFF; end
      else start_i = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (cyc <= int'(t.nv) && cyc <= 64) begin
        ev = vec_at(t.seed, cyc - 1, t.ls, t.inj, t.inj_idx);
        av = {sel2_o, sel1_o, B1_o, A1_o, B0_o, A0_o};
        chk("operands", av, ev);
        if (cyc == 1 && t.seed == 16'h1234) begin
          chk("first_A0", A0_o, 4);
          chk("first_B0", B0_o, 3);
        end
      end
      if (done_o) got = 1;
    end
    start_i = 1'b0;
    chk("done_seen", got, 1);
    exp_done = (t.nv == 0) ? 1 : int'(t.nv) + ALU_LAT + 1;
    chk("done_cycle", cyc, exp_done);
    chk("busy_at_done", busy_o, 0);
    if (t.use_model) begin
      model_exp(t, e_err, e_first);
      chk("err_cnt_model", err_cnt_o, e_err);
      chk("fail_vld_model", fail_vld_o, e_first >= 0);
      if (e_first >= 0) chk("fail_idx_model", fail_idx_o, e_first);
    end else begin
      chk("err_cnt", err_cnt_o, t.exp_err);
      chk("fail_vld", fail_vld_o, t.exp_fvld);
      if (t.exp_fvld) begin
        chk("fail_idx", fail_idx_o, t.exp_fidx);
        ev = vec_at(t.seed, int'(t.exp_fidx), t.ls, t.inj, t.inj_idx);
        chk("fail_vec", fail_vec_o, ev);
      end
    end
    if (t.nv == 0) chk("ops_unchanged", {sel2_o, sel1_o, B1_o, A1_o, B0_o, A0_o}, ops0);
    @(posedge clk); #1;
    chk("done_one_cycle", done_o, 0);
    chk("err_hold", err_cnt_o, t.use_model ? err_cnt_o : {16'h0, t.exp_err});
  endtask

  vec_t tbl [9];
  vec_t big;

  initial begin
    logic [19:0] ev;
    logic [3:0]  a1x;
    tbl[0] = '{16'h0000, 16'd8,  1'b1, 1'b0, 16'd0,  -1, 1'b0, 16'd0, 1'b0, 16'd0};
    tbl[1] = '{16'h0000, 16'd10, 1'b1, 1'b1, 16'd3,  -1, 1'b0, 16'd1, 1'b1, 16'd3};
    tbl[2] = '{16'h0000, 16'd0,  1'b1, 1'b0, 16'd0,  -1, 1'b0, 16'd0, 1'b0, 16'd0};
    tbl[3] = '{16'h1234, 16'd6,  1'b1, 1'b0, 16'd0,   2, 1'b0, 16'd0, 1'b0, 16'd0};
    tbl[4] = '{16'hBEEF, 16'd12, 1'b1, 1'b1, 16'd11, -1, 1'b0, 16'd1, 1'b1, 16'd11};
    tbl[5] = '{16'h0001, 16'd5,  1'b1, 1'b1, 16'd0,  -1, 1'b0, 16'd1, 1'b1, 16'd0};
    tbl[6] = '{16'h5A5A, 16'd4,  1'b1, 1'b1, 16'd7,  -1, 1'b0, 16'd0, 1'b0, 16'd0};
    tbl[7] = '{16'h0000, 16'd1,  1'b1, 1'b0, 16'd0,  -1, 1'b0, 16'd0, 1'b0, 16'd0};
    tbl[8] = '{16'h1357, 16'd16, 1'b0, 1'b0, 16'd0,  -1, 1'b1, 16'd0, 1'b0, 16'd0};

    rst = 1'b1; start_i = 1'b0; num_vec_i = '0; seed_i = '0;
    lockstep_i = 1'b1; inj_en_i = 1'b0; inj_idx_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ops", {sel2_o, sel1_o, B1_o, A1_o, B0_o, A0_o}, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_fail", {fail_vld_o, fail_idx_o, fail_vec_o}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_run(tbl[i]);

    // Injected A1 must be A0 with bit 0 flipped (vector 3 of the default seed)
    do_run(tbl[1]);
    ev  = vec_at(16'h0, 3, 1'b1, 1'b0, 16'd0);
    a1x = fail_vec_o[11:8];
    chk("inj_a1_bits", a1x, {ev[3:1], ~ev[0]});

    // Reset in the middle of ISSUE aborts without a done pulse
    seed_i = 16'h0; num_vec_i = 16'd20; lockstep_i = 1'b1;
    inj_en_i = 1'b1; inj_idx_i = 16'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_err", err_cnt_o, 1);
    chk("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ops", {sel2_o, sel1_o, B1_o, A1_o, B0_o, A0_o}, 0);
    chk("midrst_busy_done", {busy_o, done_o}, 0);
    chk("midrst_err", err_cnt_o, 0);
    chk("midrst_fail", {fail_vld_o, fail_idx_o, fail_vec_o}, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {busy_o, done_o}, 0);
    end
    inj_en_i = 1'b0;
    do_run(tbl[0]);

    // Every result reports a carry mismatch: count reaches all-ones
    force_y = 1'b1;
    big = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'd0, -1, 1'b0, 16'hFFFF, 1'b1, 16'd0};
    do_run(big);
    force_y = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
